biu_cache_arbiter: RTL and testbench
====================================

# biu_cache_arbiter

Two-requester arbiter that shares the BIU's single cache-line request/response port between the I-cache refill path and the D-cache refill/writeback path. It accepts one line transaction at a time, forwards it to the BIU, captures the BIU's single-cycle response pulse into a buffer, and returns it to the owning requester under a valid/ready handshake. It sits between the two L1 cache controllers and the BIU cache port; the BIU uncache port is not touched.

## Interface
- ADDR_W, 64, request address width
- LINE_W, 512, cache line width in bits
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ic_req_vld_i / ic_req_rdy_o  in/out  1  I-cache request handshake (read only)
- ic_req_addr_i  in  ADDR_W  I-cache line address
- ic_resp_vld_o / ic_resp_rdy_i  out/in  1  I-cache response handshake
- ic_resp_rdata_o  out  LINE_W  response line; ic_resp_err_o  out  1  error
- dc_req_vld_i / dc_req_rdy_o  in/out  1  D-cache request handshake
- dc_req_rd_i  in  1  1=refill read, 0=writeback
- dc_req_addr_i  in  ADDR_W; dc_req_wdata_i  in  LINE_W  writeback data
- dc_resp_vld_o / dc_resp_rdy_i  out/in  1; dc_resp_rdata_o  out  LINE_W; dc_resp_err_o  out  1
- biu_req_vld_o / biu_req_rdy_i  out/in  1  to BIU cache request port
- biu_req_rd_o  out  1; biu_req_addr_o  out  ADDR_W; biu_req_wdata_o  out  LINE_W
- biu_resp_vld_i / biu_resp_rdy_o  in/out  1; biu_resp_rdata_i  in  LINE_W; biu_resp_err_i  in  1
- busy_o  out  1  high whenever state != IDLE

## Operation
- States: IDLE, REQ, WAIT, RESP. One outstanding transaction maximum.
- IDLE: if any req_vld, pick winner; winner's req_rdy_o=1 combinationally (state==IDLE && grant); on that edge latch rd (ic forces rd=1), addr, wdata (ic: zero), owner; go REQ. Loser's rdy_o=0.
- REQ: biu_req_vld_o=1 with latched fields held stable; on biu_req_rdy_i go WAIT.
- WAIT: biu_resp_rdy_o=1 unconditionally (BIU pulses resp for one cycle, ignoring ready). On biu_resp_vld_i latch rdata/err into response buffer, go RESP.
- RESP: owner's resp_vld_o=1, held until owner's resp_rdy_i; then IDLE. Non-owner resp_vld_o=0.
- Both resp_rdata_o/resp_err_o buses driven from the shared response buffer; only vld qualifies.
- biu_req_addr_o = {addr[ADDR_W-1:6], 6'b0}; low 6 bits of requester addresses discarded.
- biu_resp_vld_i outside WAIT: ignored (biu_resp_rdy_o=0), no state change.
- Requester vld deasserting while not granted: no effect; no request is remembered across IDLE cycles.

## Timing
- Reset values: all *_rdy_o, *_vld_o, busy_o, err outputs 0; addr/data outputs 0; state IDLE; last_grant=IC.
- Accept at edge T; biu_req_vld_o high from T+1. BIU rdy at T+1 → WAIT from T+2.
- BIU resp at cycle R → owner resp_vld_o from R+1; owner rdy at R+1 → IDLE at R+2; next accept possible in cycle R+2.
- Minimum back-to-back spacing: 4 cycles plus BIU latency.
- rst_n asserted mid-transaction: immediate return to IDLE, buffers cleared, transaction abandoned (BIU shares rst_n).

## Configuration
- BIU_CACHE_ARB_RR_EN defined: round-robin; on simultaneous vld the requester not equal to last_grant wins; last_grant updates on every accept. Reset last_grant=IC, so first tie goes to DC.
- Undefined: fixed priority, DC always wins ties; last_grant register not instantiated.

## Structure
- Package biu_arb_pkg: state enum (IDLE/REQ/WAIT/RESP), owner encoding (OWN_IC=0, OWN_DC=1), LINE_OFFSET_W=6, default ADDR_W/LINE_W.
- One sub-module: biu_arb_pick (2-way grant logic, fixed or RR per macro, holds last_grant).

## Test plan
- IC read addr 0x8000_0047, BIU rdy immediate, resp 3 cycles later data 0xA5.. → biu_req_addr_o=0x8000_0040, rd=1; ic_resp_vld_o one cycle after BIU pulse, rdata=0xA5..; dc_resp_vld_o stays 0.
- DC writeback addr 0x1000, wdata pattern W → biu_req_rd_o=0, wdata=W stable until biu_req_rdy_i after 5-cycle stall.
- IC and DC vld same cycle, 4 back-to-back rounds → RR build: grants DC,IC,DC,IC; fixed build: DC four times.
- Owner holds resp_rdy_i=0 for 10 cycles after BIU pulse → resp_vld_o and data held 10 cycles, new requests not accepted, busy_o=1.
- Spurious biu_resp_vld_i in IDLE with err=1 → ignored; no resp_vld_o asserted.
- rst_n asserted in WAIT → all outputs 0 asynchronously; after release, fresh IC request completes normally.

Source files
------------

// File: rtl/biu_arb_pkg.sv
// biu_arb_pkg: shared constants for the BIU cache-port arbiter
package biu_arb_pkg;
  localparam int DEF_ADDR_W = 64;
  localparam int DEF_LINE_W = 512;
  localparam int LINE_OFFSET_W = 6;
  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;
  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;
endpackage

// File: rtl/biu_arb_pick.sv
// biu_arb_pick: 2-way grant, fixed DC priority or round-robin under BIU_CACHE_ARB_RR_EN
module biu_arb_pick
  import biu_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic ic_vld,
  input  logic dc_vld,
  input  logic accept,
  output logic win_dc
);
`ifdef BIU_CACHE_ARB_RR_EN
  logic last_q;
  assign win_dc = dc_vld & (~ic_vld | (last_q == OWN_IC));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= OWN_IC;
    else if (accept) last_q <= win_dc;
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, rst_n, accept, ic_vld};
  assign win_dc = dc_vld;
`endif
endmodule

// File: rtl/biu_cache_arbiter.sv
// biu_cache_arbiter: shares the BIU cache-line port between I-cache and D-cache
// Round-robin arbitration when BIU_CACHE_ARB_RR_EN is defined, else fixed DC priority.
module biu_cache_arbiter
  import biu_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req_vld_i,
  output logic              ic_req_rdy_o,
  input  logic [ADDR_W-1:0] ic_req_addr_i,
  output logic              ic_resp_vld_o,
  input  logic              ic_resp_rdy_i,
  output logic [LINE_W-1:0] ic_resp_rdata_o,
  output logic              ic_resp_err_o,
  input  logic              dc_req_vld_i,
  output logic              dc_req_rdy_o,
  input  logic              dc_req_rd_i,
  input  logic [ADDR_W-1:0] dc_req_addr_i,
  input  logic [LINE_W-1:0] dc_req_wdata_i,
  output logic              dc_resp_vld_o,
  input  logic              dc_resp_rdy_i,
  output logic [LINE_W-1:0] dc_resp_rdata_o,
  output logic              dc_resp_err_o,
  output logic              biu_req_vld_o,
  input  logic              biu_req_rdy_i,
  output logic              biu_req_rd_o,
  output logic [ADDR_W-1:0] biu_req_addr_o,
  output logic [LINE_W-1:0] biu_req_wdata_o,
  input  logic              biu_resp_vld_i,
  output logic              biu_resp_rdy_o,
  input  logic [LINE_W-1:0] biu_resp_rdata_i,
  input  logic              biu_resp_err_i,
  output logic              busy_o
);
  state_t state_q, state_d;
  logic own_q, rd_q, err_q, win_dc, idle, accept, owner_rdy, unused_ok;
  logic [ADDR_W-1:LINE_OFFSET_W] addr_q;
  logic [LINE_W-1:0] wdata_q, rdata_q;
  assign unused_ok = &{1'b0, ic_req_addr_i[LINE_OFFSET_W-1:0], dc_req_addr_i[LINE_OFFSET_W-1:0]};
  assign idle = state_q == ST_IDLE;
  assign accept = idle & (ic_req_vld_i | dc_req_vld_i);
  biu_arb_pick u_pick (
    .clk   (clk),
    .rst_n (rst_n),
    .ic_vld(ic_req_vld_i),
    .dc_vld(dc_req_vld_i),
    .accept(accept),
    .win_dc(win_dc)
  );
  assign ic_req_rdy_o = idle & ic_req_vld_i & ~win_dc;
  assign dc_req_rdy_o = idle & dc_req_vld_i & win_dc;
  assign biu_req_vld_o = state_q == ST_REQ;
  assign biu_req_rd_o = rd_q;
  assign biu_req_addr_o = {addr_q, {LINE_OFFSET_W{1'b0}}};
  assign biu_req_wdata_o = wdata_q;
  assign biu_resp_rdy_o = state_q == ST_WAIT;
  assign ic_resp_vld_o = (state_q == ST_RESP) & (own_q == OWN_IC);
  assign dc_resp_vld_o = (state_q == ST_RESP) & (own_q == OWN_DC);
  assign ic_resp_rdata_o = rdata_q;
  assign dc_resp_rdata_o = rdata_q;
  assign ic_resp_err_o = err_q;
  assign dc_resp_err_o = err_q;
  assign busy_o = ~idle;
  assign owner_rdy = own_q == OWN_DC ? dc_resp_rdy_i : ic_resp_rdy_i;
  always_comb begin
    state_d = state_q;
    state_d = state_q == ST_IDLE ? (accept ? ST_REQ : ST_IDLE)
            : state_q == ST_REQ  ? (biu_req_rdy_i ? ST_WAIT : ST_REQ)
            : state_q == ST_WAIT ? (biu_resp_vld_i ? ST_RESP : ST_WAIT)
            : (owner_rdy ? ST_IDLE : ST_RESP);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      own_q   <= OWN_IC;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        own_q   <= win_dc;
        rd_q    <= win_dc ? dc_req_rd_i : 1'b1;
        addr_q  <= win_dc ? dc_req_addr_i[ADDR_W-1:LINE_OFFSET_W] : ic_req_addr_i[ADDR_W-1:LINE_OFFSET_W];
        wdata_q <= win_dc ? dc_req_wdata_i : '0;
      end
      if (biu_resp_rdy_o && biu_resp_vld_i) begin
        rdata_q <= biu_resp_rdata_i;
        err_q   <= biu_resp_err_i;
      end
    end
endmodule

// File: tb/tb_biu_cache_arbiter.sv
// tb_biu_cache_arbiter: table-driven transactions plus reset and spurious-response sequences
module tb_biu_cache_arbiter;
  logic clk = 0, rst_n = 0;
  logic ic_req_vld = 0, ic_resp_rdy = 0, dc_req_vld = 0, dc_req_rd = 0, dc_resp_rdy = 0;
  logic biu_req_rdy = 0, biu_resp_vld = 0, biu_resp_err = 0;
  logic [63:0] ic_req_addr = '0, dc_req_addr = '0;
  logic [511:0] dc_req_wdata = '0, biu_resp_rdata = '0;
  logic ic_req_rdy_o, ic_resp_vld_o, ic_resp_err_o, dc_req_rdy_o, dc_resp_vld_o, dc_resp_err_o;
  logic biu_req_vld_o, biu_req_rd_o, biu_resp_rdy_o, busy_o;
  logic [63:0] biu_req_addr_o;
  logic [511:0] ic_resp_rdata_o, dc_resp_rdata_o, biu_req_wdata_o;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic ic, dc, rd;
    logic [63:0] ic_addr, dc_addr;
    logic [511:0] wdata, rdata;
    logic err;
    int stall, lat, hold;
    logic own;
    logic exp_rd;
    logic [63:0] exp_addr;
  } vec_t;
  vec_t tv[8];
  biu_cache_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req_vld_i(ic_req_vld), .ic_req_rdy_o(ic_req_rdy_o), .ic_req_addr_i(ic_req_addr),
    .ic_resp_vld_o(ic_resp_vld_o), .ic_resp_rdy_i(ic_resp_rdy),
    .ic_resp_rdata_o(ic_resp_rdata_o), .ic_resp_err_o(ic_resp_err_o),
    .dc_req_vld_i(dc_req_vld), .dc_req_rdy_o(dc_req_rdy_o), .dc_req_rd_i(dc_req_rd),
    .dc_req_addr_i(dc_req_addr), .dc_req_wdata_i(dc_req_wdata),
    .dc_resp_vld_o(dc_resp_vld_o), .dc_resp_rdy_i(dc_resp_rdy),
    .dc_resp_rdata_o(dc_resp_rdata_o), .dc_resp_err_o(dc_resp_err_o),
    .biu_req_vld_o(biu_req_vld_o), .biu_req_rdy_i(biu_req_rdy), .biu_req_rd_o(biu_req_rd_o),
    .biu_req_addr_o(biu_req_addr_o), .biu_req_wdata_o(biu_req_wdata_o),
    .biu_resp_vld_i(biu_resp_vld), .biu_resp_rdy_o(biu_resp_rdy_o),
    .biu_resp_rdata_i(biu_resp_rdata), .biu_resp_err_i(biu_resp_err),
    .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic run(input vec_t r);
    logic [511:0] ew;
    ew = r.own ? r.wdata : '0;
    @(negedge clk);
    ic_req_vld = r.ic; dc_req_vld = r.dc; dc_req_rd = r.rd;
    ic_req_addr = r.ic_addr; dc_req_addr = r.dc_addr; dc_req_wdata = r.wdata;
    #1;
    chk("ic_req_rdy", ic_req_rdy_o, r.ic && !r.own);
    chk("dc_req_rdy", dc_req_rdy_o, r.own);
    @(negedge clk);
    ic_req_vld = 0; dc_req_vld = 0; ic_req_addr = '1; dc_req_addr = '1; dc_req_wdata = '1; dc_req_rd = ~r.rd;
    chk("biu_req_vld", biu_req_vld_o, 1);
    chk("biu_req_rd", biu_req_rd_o, r.exp_rd);
    chk("biu_req_addr", biu_req_addr_o, r.exp_addr);
    chk("biu_req_wdata", biu_req_wdata_o, ew);
    chk("busy_req", busy_o, 1);
    repeat (r.stall) begin
      @(negedge clk);
      chk("stall_vld", biu_req_vld_o, 1);
      chk("stall_wdata", biu_req_wdata_o, ew);
      chk("stall_addr", biu_req_addr_o, r.exp_addr);
    end
    biu_req_rdy = 1;
    @(negedge clk);
    biu_req_rdy = 0;
    chk("wait_req_vld", biu_req_vld_o, 0);
    chk("wait_resp_rdy", biu_resp_rdy_o, 1);
    repeat (r.lat - 1) begin
      @(negedge clk);
      chk("wait_no_resp", ic_resp_vld_o | dc_resp_vld_o, 0);
    end
    biu_resp_vld = 1; biu_resp_rdata = r.rdata; biu_resp_err = r.err;
    @(negedge clk);
    biu_resp_vld = 0; biu_resp_rdata = '0; biu_resp_err = 0;
    chk("own_resp_vld", r.own ? dc_resp_vld_o : ic_resp_vld_o, 1);
    chk("other_resp_vld", r.own ? ic_resp_vld_o : dc_resp_vld_o, 0);
    chk("resp_rdata", r.own ? dc_resp_rdata_o : ic_resp_rdata_o, r.rdata);
    chk("resp_err", r.own ? dc_resp_err_o : ic_resp_err_o, r.err);
    ic_req_vld = 1; dc_req_vld = 1;
    repeat (r.hold) begin
      @(negedge clk);
      chk("hold_vld", r.own ? dc_resp_vld_o : ic_resp_vld_o, 1);
      chk("hold_rdata", r.own ? dc_resp_rdata_o : ic_resp_rdata_o, r.rdata);
      chk("hold_busy", busy_o, 1);
      chk("hold_no_accept", ic_req_rdy_o | dc_req_rdy_o, 0);
    end
    ic_req_vld = 0; dc_req_vld = 0;
    if (r.own) dc_resp_rdy = 1; else ic_resp_rdy = 1;
    @(negedge clk);
    dc_resp_rdy = 0; ic_resp_rdy = 0;
    chk("done_busy", busy_o, 0);
    chk("done_resp_vld", ic_resp_vld_o | dc_resp_vld_o, 0);
  endtask
  initial begin
    tv[0] = '{1, 0, 0, 64'h8000_0047, 64'h0, '0, {64{8'hA5}}, 0, 0, 3, 0, 0, 1, 64'h8000_0040};
    tv[1] = '{0, 1, 0, 64'h0, 64'h1000, {8{64'hDEAD_BEEF_0123_4567}}, {16{32'h1234_5678}}, 0, 5, 1, 0, 1, 0, 64'h1000};
    tv[2] = '{0, 1, 1, 64'h0, 64'h2000_003F, {8{64'h5555_0000_AAAA_FFFF}}, {64{8'h3C}}, 1, 1, 2, 10, 1, 1, 64'h2000_0000};
    tv[3] = '{1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, '0, {64{8'h96}}, 1, 0, 1, 2, 0, 1, 64'hFFFF_FFFF_FFFF_FFC0};
    for (int i = 4; i < 8; i++) begin
`ifdef BIU_CACHE_ARB_RR_EN
      tv[i] = '{1, 1, 1, 64'h0000_0105, 64'h0000_0207, {8{64'h0F0F_1111_2222_3333}}, {16{32'h0BAD_C0DE + i}}, 0, 0, 1, 0,
                (i % 2 == 0), 1, (i % 2 == 0) ? 64'h0000_0200 : 64'h0000_0100};
`else
      tv[i] = '{1, 1, 1, 64'h0000_0105, 64'h0000_0207, {8{64'h0F0F_1111_2222_3333}}, {16{32'h0BAD_C0DE + i}}, 0, 0, 1, 0,
                1, 1, 64'h0000_0200};
`endif
    end
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_biu_req_vld", biu_req_vld_o, 0);
    chk("rst_biu_resp_rdy", biu_resp_rdy_o, 0);
    chk("rst_addr", biu_req_addr_o, 0);
    chk("rst_wdata", biu_req_wdata_o, 0);
    chk("rst_rd", biu_req_rd_o, 0);
    chk("rst_resp_vld", ic_resp_vld_o | dc_resp_vld_o, 0);
    chk("rst_err", ic_resp_err_o | dc_resp_err_o, 0);
    chk("rst_rdata", ic_resp_rdata_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
      end
      run(tv[i]);
    end
    @(negedge clk);
    biu_resp_vld = 1; biu_resp_err = 1; biu_resp_rdata = '1;
    #1;
    chk("spur_resp_rdy", biu_resp_rdy_o, 0);
    @(negedge clk);
    biu_resp_vld = 0; biu_resp_err = 0; biu_resp_rdata = '0;
    chk("spur_busy", busy_o, 0);
    chk("spur_resp_vld", ic_resp_vld_o | dc_resp_vld_o, 0);
    chk("spur_err", ic_resp_err_o, 0);
    chk("spur_rdata", ic_resp_rdata_o, tv[7].rdata);
    @(negedge clk);
    ic_req_vld = 1; ic_req_addr = 64'h40;
    @(negedge clk);
    ic_req_vld = 0; biu_req_rdy = 1;
    @(negedge clk);
    biu_req_rdy = 0;
    chk("arst_in_wait", biu_resp_rdy_o, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_resp_rdy", biu_resp_rdy_o, 0);
    chk("arst_addr", biu_req_addr_o, 0);
    chk("arst_rd", biu_req_rd_o, 0);
    chk("arst_rdata", ic_resp_rdata_o, 0);
    @(negedge clk);
    rst_n = 1;
    run(tv[0]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
